alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single combinational 32-bit ALU between two requesters: req0 is the execute stage and req1 is the address/branch helper.
- Uses round-robin arbitration with a valid/ready handshake on each request port.
- Drives the ALU operand and control inputs combinationally from the granted request.
- Captures alu_out and zero into a one-entry response register, which is returned with a requester ID under valid/ready backpressure.

Parameters:
- W, 32: operand and result width. It must equal the ALU width; only 32 is supported.
- FLAG_ILLEGAL, 1: when 1, an op code outside the supported set sets resp_err. When 0, resp_err is tied to 0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  4  ALU control code for requester 0
- req0_a  in  W  operand 1 for requester 0
- req0_b  in  W  operand 2 for requester 0
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as req0, for requester 1
- alu_in_1  out  W  ALU operand 1 (combinational mux)
- alu_in_2  out  W  ALU operand 2 (combinational mux)
- alu_ctrl  out  4  ALU control (combinational mux)
- alu_out  in  W  ALU result
- alu_zero  in  1  ALU zero flag
- resp_valid  out  1  response register holds a result
- resp_ready  in  1  consumer accepts the response
- resp_id  out  1  requester that owns the response
- resp_data  out  W  captured alu_out
- resp_zero  out  1  captured alu_zero
- resp_err  out  1  op code was not a supported code

Behaviour:
- Reset: synchronous, active-low, sampled on the clk rising edge. The ALU's rst_n is tied to the same rst_n.
  - On reset: resp_valid=0, resp_id=0, resp_data=0, resp_zero=0, resp_err=0, priority pointer=0 (req0 preferred).
  - While rst_n=0: req0_ready=req1_ready=0, and alu_in_1, alu_in_2 and alu_ctrl are driven 0.
  - Reset mid-operation discards any held response; it is not replayed.
- Capacity: can_accept = !resp_valid | resp_ready.
- Grant (combinational):
  - If can_accept and only one valid is high, that requester wins.
  - If both valids are high, the requester named by the priority pointer wins.
  - Exactly one ready is high, the winner's; the loser's ready is 0.
- ALU drive: alu_in_1, alu_in_2 and alu_ctrl carry the winner's a, b and op. With no grant they are driven 0 (ctrl 0000).
- Requester rules: each requester holds a, b and op stable while valid=1 and ready=0. Withdrawing valid before ready is permitted; nothing is recorded.
- Latency: a handshake in cycle N loads the response register at the rising edge ending cycle N:
  - resp_data=alu_out, resp_zero=alu_zero, resp_id=winner index, resp_err=illegal(op).
  - resp_valid=1 from cycle N+1. Throughput is one result per cycle while resp_ready=1.
- Response hold: while resp_valid=1 and resp_ready=0, all resp_* outputs are stable and no grant is issued.
- Drain with no new grant: resp_valid=1, resp_ready=1 and no grant clears resp_valid at the next edge.
- Simultaneous drain and grant: the new result replaces the drained one and resp_valid stays 1.
- Priority pointer: after each grant it is set to the index opposite the winner. It is unchanged in cycles with no grant.
- Legal op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1000 unsigned set-less-than, 1001 SLL, 1010 SRA.
- Illegal op codes: any other code is still issued to the ALU (which returns 0); resp_data=0 and resp_err=1 when FLAG_ILLEGAL=1.
- Zero flag: resp_zero is passed through unmodified. It is only meaningful for codes with bit2=1 (SUB); the arbiter does not recompute it.
- Structure: no internal FSM beyond the response-valid bit and the priority pointer. There are no combinational paths from resp_ready to ALU inputs other than through can_accept.

Test Plan:
1. Reset and single request: reset then release; req0 ADD a=5, b=7, resp_ready=1 → req0_ready=1 same cycle, next cycle resp_valid=1, resp_id=0, resp_data=12, resp_zero=0, resp_err=0.
2. Contention and alternation: both requesters hold valid for 4 cycles (req0 SUB 9-9, req1 OR 0xF0|0x0F), resp_ready=1 → grants alternate 0,1,0,1; req0 results have data=0 and zero=1; req1 results have data=0xFF.
3. Backpressure: response pending with resp_ready=0 for 3 cycles while req1 is valid → req1_ready=0 throughout and resp_* stable. Raise resp_ready → req1 granted that same cycle; its result appears the next cycle with no idle bubble.
4. Illegal op: req1 op=0011, a=1, b=1 → resp_data=0, resp_err=1, resp_id=1, and the pointer advances to 0.
5. Shift and compare: req0 SRA a=0x80000000, b=4 → 0xF8000000. req0 SLT a=3, b=0xFFFFFFFF → 1 (unsigned).
6. Reset mid-operation: rst_n=0 while resp_valid=1 and both requesters are valid → next edge resp_valid=0, both readies 0, ALU inputs 0. After release, req0 wins the first contention.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Bundle of the two request ports, the shared-ALU drive/return lines and the
// response port. The arbiter takes the slave view; the environment takes master.
interface alu_share_arbiter_if #(
  parameter int W = 32
);
  logic         req0_valid;
  logic         req0_ready;
  logic [3:0]   req0_op;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;

  logic         req1_valid;
  logic         req1_ready;
  logic [3:0]   req1_op;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;

  logic [W-1:0] alu_in_1;
  logic [W-1:0] alu_in_2;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_out;
  logic         alu_zero;

  logic         resp_valid;
  logic         resp_ready;
  logic         resp_id;
  logic [W-1:0] resp_data;
  logic         resp_zero;
  logic         resp_err;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_in_1, alu_in_2, alu_ctrl,
    input  alu_out, alu_zero,
    output resp_valid, resp_id, resp_data, resp_zero, resp_err,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_in_1, alu_in_2, alu_ctrl,
    output alu_out, alu_zero,
    input  resp_valid, resp_id, resp_data, resp_zero, resp_err,
    output resp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational 32-bit ALU between the execute stage
// (req0) and the address/branch helper (req1), with a one-entry response register.
module alu_share_arbiter #(
  parameter int W            = 32,
  parameter bit FLAG_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_share_arbiter_if.slave bus
);

  function automatic logic is_illegal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110,
      4'b1000, 4'b1001, 4'b1010: is_illegal = 1'b0;
      default:                   is_illegal = 1'b1;
    endcase
  endfunction

  logic         resp_valid_q, resp_valid_d;
  logic         resp_id_q,    resp_id_d;
  logic [W-1:0] resp_data_q,  resp_data_d;
  logic         resp_zero_q,  resp_zero_d;
  logic         resp_err_q,   resp_err_d;
  logic         ptr_q,        ptr_d;

  logic         can_accept;
  logic         grant0;
  logic         grant1;
  logic         grant_any;
  logic [3:0]   op_sel;
  logic [W-1:0] a_sel;
  logic [W-1:0] b_sel;

  // Grant: a free response slot is needed; on contention the pointer picks.
  always_comb begin
    can_accept = !resp_valid_q || bus.resp_ready;
    grant0     = rst_n && can_accept && bus.req0_valid && (!bus.req1_valid || !ptr_q);
    grant1     = rst_n && can_accept && bus.req1_valid && (!bus.req0_valid ||  ptr_q);
    grant_any  = grant0 || grant1;
    op_sel     = 4'b0000;
    a_sel      = '0;
    b_sel      = '0;
    if (grant0) begin
      op_sel = bus.req0_op;
      a_sel  = bus.req0_a;
      b_sel  = bus.req0_b;
    end else if (grant1) begin
      op_sel = bus.req1_op;
      a_sel  = bus.req1_a;
      b_sel  = bus.req1_b;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.alu_in_1   = a_sel;
  assign bus.alu_in_2   = b_sel;
  assign bus.alu_ctrl   = op_sel;

  // A new result overwrites the slot even when it is being drained this cycle.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_zero_d  = resp_zero_q;
    resp_err_d   = resp_err_q;
    ptr_d        = ptr_q;
    if (grant_any) begin
      resp_valid_d = 1'b1;
      resp_id_d    = grant1;
      resp_data_d  = bus.alu_out;
      resp_zero_d  = bus.alu_zero;
      resp_err_d   = FLAG_ILLEGAL && is_illegal(op_sel);
      ptr_d        = grant0;
    end else if (bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_zero_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      ptr_q        <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_zero_q  <= resp_zero_d;
      resp_err_q   <= resp_err_d;
      ptr_q        <= ptr_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_zero  = resp_zero_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a behavioural model.
module tb_alu_share_arbiter;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_BAD = 4'b0011;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  alu_share_arbiter_if #(.W(32)) bus ();

  alu_share_arbiter #(.W(32), .FLAG_ILLEGAL(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      OP_AND:  alu_ref = a & b;
      OP_OR:   alu_ref = a | b;
      OP_ADD:  alu_ref = a + b;
      OP_SUB:  alu_ref = a - b;
      OP_SLT:  alu_ref = (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  alu_ref = a << b[4:0];
      OP_SRA:  alu_ref = sa >>> b[4:0];
      default: alu_ref = 32'd0;
    endcase
  endfunction

  function automatic logic legal_op(input logic [3:0] op);
    legal_op = op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLL, OP_SRA};
  endfunction

  // Stand-in for the shared ALU.
  assign bus.alu_out  = alu_ref(bus.alu_ctrl, bus.alu_in_1, bus.alu_in_2);
  assign bus.alu_zero = (alu_ref(bus.alu_ctrl, bus.alu_in_1, bus.alu_in_2) == 32'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v0, input logic [3:0] op0, input logic [31:0] a0,
                        input logic [31:0] b0, input logic v1, input logic [3:0] op1,
                        input logic [31:0] a1, input logic [31:0] b1, input logic rr);
    bus.req0_valid = v0;  bus.req0_op = op0;  bus.req0_a = a0;  bus.req0_b = b0;
    bus.req1_valid = v1;  bus.req1_op = op1;  bus.req1_a = a1;  bus.req1_b = b1;
    bus.resp_ready = rr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        v0;
    logic [3:0]  op0;
    logic [31:0] a0, b0;
    logic        v1;
    logic [3:0]  op1;
    logic [31:0] a1, b1;
    logic        e_r0, e_r1, e_rv, e_id;
    logic [31:0] e_data;
    logic        e_zero, e_err, full;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic v0, input logic [3:0] op0,
                              input logic [31:0] a0, input logic [31:0] b0, input logic v1,
                              input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                              input logic e_r0, input logic e_r1, input logic e_rv,
                              input logic e_id, input logic [31:0] e_data, input logic e_zero,
                              input logic e_err, input logic full);
    vec_t t;
    t.rst = rst; t.v0 = v0; t.op0 = op0; t.a0 = a0; t.b0 = b0;
    t.v1 = v1; t.op1 = op1; t.a1 = a1; t.b1 = b1;
    t.e_r0 = e_r0; t.e_r1 = e_r1; t.e_rv = e_rv; t.e_id = e_id;
    t.e_data = e_data; t.e_zero = e_zero; t.e_err = e_err; t.full = full;
    return t;
  endfunction

  // Behavioural model state for the random phase.
  logic        m_valid, m_id, m_zero, m_err, m_ptr;
  logic [31:0] m_data;
  logic        g0, g1, can;
  logic        rv0, rv1, rrr, rrst, hold0, hold1;
  logic [3:0]  rop0, rop1;
  logic [31:0] ra0, rb0, ra1, rb1;

  function automatic logic [3:0] pick_op();
    case ($urandom_range(0, 8))
      0: pick_op = OP_AND;
      1: pick_op = OP_OR;
      2: pick_op = OP_ADD;
      3: pick_op = OP_SUB;
      4: pick_op = OP_SLT;
      5: pick_op = OP_SLL;
      6: pick_op = OP_SRA;
      default: pick_op = 4'($urandom_range(0, 15));
    endcase
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 3))
      0: pick_val = 32'($urandom_range(0, 8));
      1: pick_val = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      2: pick_val = 32'h8000_0000 | 32'($urandom_range(0, 255));
      default: pick_val = $urandom;
    endcase
  endfunction

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    step();

    // Directed table: one row per cycle, resp_ready held at 1.
    tbl.push_back(mk(0, 1, OP_ADD, 5, 7, 0, 0, 0, 0,               0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, OP_ADD, 5, 7, 0, 0, 0, 0,               1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, OP_OR, 32'hF0, 32'h0F,      0, 1, 1, 0, 12, 0, 0, 0));
    tbl.push_back(mk(1, 1, OP_SUB, 9, 9, 1, OP_OR, 32'hF0, 32'h0F, 1, 0, 1, 1, 32'hFF, 0, 0, 0));
    tbl.push_back(mk(1, 1, OP_SUB, 9, 9, 1, OP_OR, 32'hF0, 32'h0F, 0, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, OP_SUB, 9, 9, 1, OP_OR, 32'hF0, 32'h0F, 1, 0, 1, 1, 32'hFF, 0, 0, 0));
    tbl.push_back(mk(1, 1, OP_SUB, 9, 9, 1, OP_OR, 32'hF0, 32'h0F, 0, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 1, 1, 32'hFF, 0, 0, 0));
    tbl.push_back(mk(1, 1, OP_ADD, 1, 1, 0, 0, 0, 0,               1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, OP_BAD, 1, 1,               0, 1, 1, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 1, OP_ADD, 2, 3, 1, OP_ADD, 10, 20,        1, 0, 1, 1, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, OP_ADD, 10, 20,             0, 1, 1, 0, 5, 0, 0, 0));
    tbl.push_back(mk(1, 1, OP_SRA, 32'h8000_0000, 4, 0, 0, 0, 0,   1, 0, 1, 1, 30, 0, 0, 0));
    tbl.push_back(mk(1, 1, OP_SLT, 3, 32'hFFFF_FFFF, 0, 0, 0, 0,   1, 0, 1, 0, 32'hF800_0000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, OP_SLL, 1, 31, 0, 0, 0, 0,              1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 1, 0, 32'h8000_0000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst;
      set_in(tbl[i].v0, tbl[i].op0, tbl[i].a0, tbl[i].b0,
             tbl[i].v1, tbl[i].op1, tbl[i].a1, tbl[i].b1, 1'b1);
      #1;
      chk($sformatf("row%0d req0_ready", i), 32'(bus.req0_ready), 32'(tbl[i].e_r0));
      chk($sformatf("row%0d req1_ready", i), 32'(bus.req1_ready), 32'(tbl[i].e_r1));
      chk($sformatf("row%0d alu_in_1", i), bus.alu_in_1,
          tbl[i].e_r0 ? tbl[i].a0 : (tbl[i].e_r1 ? tbl[i].a1 : 32'd0));
      chk($sformatf("row%0d alu_ctrl", i), 32'(bus.alu_ctrl),
          32'(tbl[i].e_r0 ? tbl[i].op0 : (tbl[i].e_r1 ? tbl[i].op1 : 4'd0)));
      chk($sformatf("row%0d resp_valid", i), 32'(bus.resp_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv || tbl[i].full) begin
        chk($sformatf("row%0d resp_id", i), 32'(bus.resp_id), 32'(tbl[i].e_id));
        chk($sformatf("row%0d resp_data", i), bus.resp_data, tbl[i].e_data);
        chk($sformatf("row%0d resp_zero", i), 32'(bus.resp_zero), 32'(tbl[i].e_zero));
        chk($sformatf("row%0d resp_err", i), 32'(bus.resp_err), 32'(tbl[i].e_err));
      end
      step();
    end

    // Backpressure: held response blocks req1, then drain and grant in one cycle.
    set_in(1, OP_ADD, 4, 4, 0, 0, 0, 0, 1);
    #1;
    chk("bp accept req0", 32'(bus.req0_ready), 32'd1);
    step();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, 0, 0, 1, OP_SUB, 10, 3, 0);
      #1;
      chk($sformatf("bp%0d req1_ready", k), 32'(bus.req1_ready), 32'd0);
      chk($sformatf("bp%0d alu_ctrl", k), 32'(bus.alu_ctrl), 32'd0);
      chk($sformatf("bp%0d resp_valid", k), 32'(bus.resp_valid), 32'd1);
      chk($sformatf("bp%0d resp_id", k), 32'(bus.resp_id), 32'd0);
      chk($sformatf("bp%0d resp_data", k), bus.resp_data, 32'd8);
      step();
    end
    set_in(0, 0, 0, 0, 1, OP_SUB, 10, 3, 1);
    #1;
    chk("bp release req1_ready", 32'(bus.req1_ready), 32'd1);
    chk("bp release resp_data", bus.resp_data, 32'd8);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("bp next resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("bp next resp_id", 32'(bus.resp_id), 32'd1);
    chk("bp next resp_data", bus.resp_data, 32'd7);
    step();
    #1;
    chk("bp drained resp_valid", 32'(bus.resp_valid), 32'd0);

    // Reset while a response is held and both requesters are valid.
    set_in(1, OP_ADD, 1, 2, 0, 0, 0, 0, 0);
    #1;
    chk("rst pre req0_ready", 32'(bus.req0_ready), 32'd1);
    step();
    rst_n = 1'b0;
    set_in(1, OP_ADD, 6, 6, 1, OP_OR, 1, 2, 0);
    #1;
    chk("rst req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("rst req1_ready", 32'(bus.req1_ready), 32'd0);
    chk("rst alu_in_1", bus.alu_in_1, 32'd0);
    chk("rst alu_in_2", bus.alu_in_2, 32'd0);
    chk("rst alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    chk("rst held resp_valid", 32'(bus.resp_valid), 32'd1);
    step();
    rst_n = 1'b1;
    set_in(1, OP_ADD, 6, 6, 1, OP_OR, 1, 2, 1);
    #1;
    chk("post-rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("post-rst resp_data", bus.resp_data, 32'd0);
    chk("post-rst req0_ready", 32'(bus.req0_ready), 32'd1);
    chk("post-rst req1_ready", 32'(bus.req1_ready), 32'd0);
    chk("post-rst alu_in_1", bus.alu_in_1, 32'd6);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("post-rst resp_data 12", bus.resp_data, 32'd12);
    chk("post-rst resp_id", 32'(bus.resp_id), 32'd0);

    // Randomized traffic against the behavioural model.
    rst_n = 1'b0;
    step();
    m_valid = 0; m_id = 0; m_data = 0; m_zero = 0; m_err = 0; m_ptr = 0;
    hold0 = 0; hold1 = 0;
    rv0 = 0; rv1 = 0; rop0 = 0; rop1 = 0; ra0 = 0; rb0 = 0; ra1 = 0; rb1 = 0;
    for (int c = 0; c < 800; c++) begin
      rrst = ($urandom_range(0, 79) != 0);
      if (hold0) begin
        if ($urandom_range(0, 9) == 0) rv0 = 1'b0;
      end else begin
        rv0 = ($urandom_range(0, 2) != 0);
        rop0 = pick_op(); ra0 = pick_val(); rb0 = pick_val();
        if ($urandom_range(0, 4) == 0) rb0 = ra0;
      end
      if (hold1) begin
        if ($urandom_range(0, 9) == 0) rv1 = 1'b0;
      end else begin
        rv1 = ($urandom_range(0, 2) != 0);
        rop1 = pick_op(); ra1 = pick_val(); rb1 = pick_val();
        if ($urandom_range(0, 4) == 0) rb1 = ra1;
      end
      rrr = ($urandom_range(0, 3) != 0);
      rst_n = rrst;
      set_in(rv0, rop0, ra0, rb0, rv1, rop1, ra1, rb1, rrr);
      #1;
      can = !m_valid || rrr;
      g0 = rrst && can && rv0 && (!rv1 || m_ptr == 1'b0);
      g1 = rrst && can && rv1 && (!rv0 || m_ptr == 1'b1);
      chk($sformatf("rnd%0d req0_ready", c), 32'(bus.req0_ready), 32'(g0));
      chk($sformatf("rnd%0d req1_ready", c), 32'(bus.req1_ready), 32'(g1));
      chk($sformatf("rnd%0d alu_in_1", c), bus.alu_in_1, g0 ? ra0 : (g1 ? ra1 : 32'd0));
      chk($sformatf("rnd%0d alu_in_2", c), bus.alu_in_2, g0 ? rb0 : (g1 ? rb1 : 32'd0));
      chk($sformatf("rnd%0d alu_ctrl", c), 32'(bus.alu_ctrl),
          32'(g0 ? rop0 : (g1 ? rop1 : 4'd0)));
      chk($sformatf("rnd%0d resp_valid", c), 32'(bus.resp_valid), 32'(m_valid));
      if (m_valid) begin
        chk($sformatf("rnd%0d resp_id", c), 32'(bus.resp_id), 32'(m_id));
        chk($sformatf("rnd%0d resp_data", c), bus.resp_data, m_data);
        chk($sformatf("rnd%0d resp_zero", c), 32'(bus.resp_zero), 32'(m_zero));
        chk($sformatf("rnd%0d resp_err", c), 32'(bus.resp_err), 32'(m_err));
      end
      hold0 = rv0 && !g0;
      hold1 = rv1 && !g1;
      if (!rrst) begin
        m_valid = 0; m_id = 0; m_data = 0; m_zero = 0; m_err = 0; m_ptr = 0;
      end else if (g0 || g1) begin
        m_valid = 1'b1;
        m_id    = g1;
        m_data  = g0 ? alu_ref(rop0, ra0, rb0) : alu_ref(rop1, ra1, rb1);
        m_zero  = (m_data == 32'd0);
        m_err   = g0 ? !legal_op(rop0) : !legal_op(rop1);
        m_ptr   = g0 ? 1'b1 : 1'b0;
      end else if (rrr) begin
        m_valid = 1'b0;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
